// File: rtl/mips_pkg.sv
// Shared constants, state encoding and sizing helpers for the instruction fetch stage.
package mips_pkg;

    // Default datapath / address width.
    localparam int unsigned DEFAULT_WIDTH    = 32;
    // Default address of the very first fetch after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // Default number of prefetch buffer entries.
    localparam int unsigned DEFAULT_DEPTH    = 2;
    // Instruction word handed to decode while nothing has been fetched.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    // Byte distance between consecutive instructions.
    localparam int unsigned INSTR_BYTES      = 4;

    // REQ  : a request is on the bus (or is being issued this cycle).
    // DROP : the outstanding request belongs to a squashed path; its data is discarded.
    // HOLD : buffered entries plus outstanding request fill the buffer, so nothing is requested.
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_DROP = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    // Width of a read/write pointer into a buffer of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of an occupancy counter that must be able to hold the value 'depth'.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_prefetch_buffer.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {instruction, pc+4} pairs with
// push, pop and flush. The head entry is shown combinationally; an empty buffer shows NOP/0.
module prefetch_buffer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW   = count_width(DEPTH)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pcplus4,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pcplus4,
    output logic [CW-1:0]    o_count,
    output logic             o_valid
);

    localparam int unsigned     PW         = ptr_width(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_instr_mem [DEPTH];
    logic [WIDTH-1:0] r_pc4_mem   [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // Qualify push/pop against occupancy; a flush overrides both.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == FULL_COUNT);
        w_do_pop  = i_pop && !w_empty && !i_flush;
        w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage write port.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage arrays are deliberately not reset; an entry is only read while
        // the count says it is live, so its power-up contents are never observed.
        if (w_do_push) begin
            r_instr_mem[r_wr_ptr] <= i_instr;
            r_pc4_mem[r_wr_ptr]   <= i_pcplus4;
        end
    end

    // Head-of-buffer view; NOP and zero PC+4 when empty.
    always_comb begin
        o_valid   = !w_empty;
        o_count   = r_count;
        o_instr   = WIDTH'(NOP_INSTR);
        o_pcplus4 = '0;
        if (!w_empty) begin
            o_instr   = r_instr_mem[r_rd_ptr];
            o_pcplus4 = r_pc4_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory, keeps
// fetched words in a small prefetch buffer, and handles decode-stage redirects.
// An outstanding request is never withdrawn: after a redirect its data is dropped.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      DEPTH    = DEFAULT_DEPTH
)(
    input  logic             CLK,
    input  logic             rst,
    input  logic             EN,
    input  logic             PCSrcD,
    input  logic [WIDTH-1:0] PCBranchD,
    output logic             IMemReq,
    output logic [WIDTH-1:0] IMemAddr,
    input  logic             IMemAck,
    input  logic [WIDTH-1:0] IMemRdata,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic             ValidF
);

    localparam int unsigned      CW          = count_width(DEPTH);
    localparam int unsigned      CW1         = CW + 1;
    localparam logic [CW:0]      DEPTH_LIMIT = CW1'(DEPTH);
    localparam logic [WIDTH-1:0] STEP        = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK  = ~WIDTH'(INSTR_BYTES - 1);

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic [WIDTH-1:0] r_pc;          // next address to fetch (bus address in REQ)
    logic [WIDTH-1:0] r_drop_addr;   // address of the squashed request held on the bus in DROP

    logic             w_req;
    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_buf_valid;
    logic [CW-1:0]    w_count;
    logic [CW:0]      w_count_next;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_redirect_pc;

    // Handshake qualification and buffer control; a redirect suppresses both push and pop.
    always_comb begin
        w_req         = rst && (r_state != FS_HOLD);
        w_ack         = w_req && IMemAck;
        w_pop         = EN && w_buf_valid && !PCSrcD;
        w_push        = w_ack && (r_state == FS_REQ) && !PCSrcD;
        w_pc_plus4    = r_pc + STEP;
        w_redirect_pc = PCBranchD & ALIGN_MASK;
        w_count_next  = {1'b0, w_count} + CW1'(w_push) - CW1'(w_pop);
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= FS_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic: redirect first, then ack/pop driven transitions.
    always_comb begin
        // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
        w_next_state = r_state;
        if (PCSrcD) begin
            w_next_state = (w_req && !w_ack) ? FS_DROP : FS_REQ;
        end else begin
            unique case (r_state)
                FS_REQ: begin
                    if (w_ack) begin
                        w_next_state = (w_count_next < DEPTH_LIMIT) ? FS_REQ : FS_HOLD;
                    end
                end
                FS_DROP: begin
                    if (w_ack) begin
                        w_next_state = FS_REQ;
                    end
                end
                FS_HOLD: begin
                    if (w_pop) begin
                        w_next_state = FS_REQ;
                    end
                end
                default: w_next_state = FS_REQ;
            endcase
        end
    end

    // Fetch PC and squashed-request address; the bus address stays put until acked.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else if (PCSrcD) begin
            r_pc <= w_redirect_pc;
            if ((r_state == FS_REQ) && !w_ack) begin
                r_drop_addr <= r_pc;
            end
        end else if (w_push) begin
            r_pc <= w_pc_plus4;
        end
    end

    // FSM outputs: request valid outside HOLD and out of reset; address of the live request.
    always_comb begin
        IMemReq  = w_req;
        IMemAddr = (r_state == FS_DROP) ? r_drop_addr : r_pc;
        ValidF   = w_buf_valid;
    end

    prefetch_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_prefetch_buffer (
        .i_clk     (CLK),
        .i_rst_n   (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (PCSrcD),
        .i_instr   (IMemRdata),
        .i_pcplus4 (w_pc_plus4),
        .o_instr   (InstrF),
        .o_pcplus4 (PCPlus4F),
        .o_count   (w_count),
        .o_valid   (w_buf_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed prologue (reset, streaming, stall,
// slow memory, redirect with drop, address wrap, reset while full) followed by
// randomized traffic. A slot-accounting reference model predicts every cycle's
// outputs into a scoreboard queue; a monitor pops and compares mid-cycle.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int unsigned WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          N_CYCLES = 800;

    logic        CLK = 1'b0;
    logic        rst;
    logic        EN;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        ValidF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    // Reference model state: fetched-but-unconsumed words, next fetch address,
    // and the single bus request (present / squashed / its address).
    entry_t      m_buf[$];
    logic [31:0] m_pc;
    logic [31:0] m_bus_addr;
    bit          m_busy;
    bit          m_discard;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    // Instruction memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign IMemRdata = mem_word(IMemAddr);

    fetch_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .EN        (EN),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemAck   (IMemAck),
        .IMemRdata (IMemRdata),
        .InstrF    (InstrF),
        .PCPlus4F  (PCPlus4F),
        .ValidF    (ValidF)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %08h, expected %08h", name, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_pc       = RESET_PC;
        m_bus_addr = RESET_PC;
        m_busy     = 1'b1;
        m_discard  = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    // One bus request may be outstanding; it occupies a buffer slot, so a new request
    // is issued only while buffered words plus that request fit in DEPTH.
    task automatic model_edge();
        bit     acked;
        entry_t e;
        if (rst !== 1'b1) return;
        acked = m_busy && (IMemAck === 1'b1);
        if (PCSrcD) begin
            m_buf.delete();
            m_pc = {PCBranchD[31:2], 2'b00};
            if (m_busy && !acked) begin
                m_discard = 1'b1;
            end else begin
                m_busy     = 1'b1;
                m_discard  = 1'b0;
                m_bus_addr = m_pc;
            end
        end else begin
            if (EN && m_buf.size() > 0) void'(m_buf.pop_front());
            if (acked) begin
                if (!m_discard) begin
                    e.instr = mem_word(m_bus_addr);
                    e.pc4   = m_bus_addr + 32'd4;
                    m_buf.push_back(e);
                    m_pc = e.pc4;
                end
                m_discard = 1'b0;
            end
            if (!m_busy || acked) begin
                m_busy     = (m_buf.size() < DEPTH);
                m_bus_addr = m_pc;
            end
        end
    endtask

    // Record what the DUT must show for the cycle now starting.
    task automatic push_expected();
        exp_t ex;
        ex.req   = (rst === 1'b1) && m_busy;
        ex.addr  = m_bus_addr;
        ex.valid = (m_buf.size() > 0);
        ex.instr = 32'h0;
        ex.pc4   = 32'h0;
        if (m_buf.size() > 0) begin
            ex.instr = m_buf[0].instr;
            ex.pc4   = m_buf[0].pc4;
        end
        exp_q.push_back(ex);
    endtask

    // Stimulus schedule: directed windows first, random traffic afterwards.
    task automatic pick_inputs(input int c);
        PCSrcD    = 1'b0;
        PCBranchD = $urandom();
        EN        = 1'b1;
        IMemAck   = 1'b1;
        if (c < 4) begin
            rst = 1'b0;                                   // held in reset
        end else if (c < 30) begin
            rst = 1'b1;                                   // zero-wait stream from RESET_PC
        end else if (c < 60) begin
            rst = 1'b1;                                   // 3-cycle decode stall, then mixed
            EN  = (c < 33) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end else if (c < 80) begin
            rst     = 1'b1;                               // slow memory: ack every 5th cycle
            IMemAck = ((c % 5) == 4);
        end else if (c < 100) begin
            rst     = 1'b1;                               // redirect while a request is unacked
            IMemAck = !(c >= 84 && c < 88);
            if (c == 85) begin
                PCSrcD    = 1'b1;
                PCBranchD = 32'h0000_0100;
            end
        end else if (c < 120) begin
            rst = 1'b1;                                   // redirect to the top word, unaligned bits set
            if (c == 104) begin
                PCSrcD    = 1'b1;
                PCBranchD = 32'hFFFF_FFFE;
            end
        end else if (c < 140) begin
            EN      = 1'b0;                               // fill up, then reset while full
            IMemAck = ($urandom_range(0, 1) == 1);
            rst     = !(c == 135 || c == 136);
        end else begin
            rst     = (rst === 1'b0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) != 0);
            EN      = ($urandom_range(0, 3) != 0);
            IMemAck = ($urandom_range(0, 9) < 6);
            PCSrcD  = ($urandom_range(0, 11) == 0);
        end
    endtask

    // Driver: inputs change 1 ns after each rising edge, after the model has absorbed that edge.
    initial begin
        rst       = 1'b0;
        EN        = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = '0;
        IMemAck   = 1'b0;
        model_reset();
        for (int c = 0; c < N_CYCLES; c++) begin
            @(posedge CLK);
            #1;
            model_edge();
            pick_inputs(c);
            if (rst !== 1'b1) model_reset();
            push_expected();
        end
        repeat (2) @(negedge CLK);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Monitor: mid-cycle, compare DUT outputs against the oldest pending prediction.
    initial begin
        exp_t ex;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("IMemReq", 32'(IMemReq), 32'(ex.req));
                if (ex.req) check("IMemAddr", IMemAddr, ex.addr);
                check("ValidF", 32'(ValidF), 32'(ex.valid));
                check("InstrF", InstrF, ex.instr);
                check("PCPlus4F", PCPlus4F, ex.pc4);
            end
        end
    end

endmodule
